// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin N:1 burst arbiter with a single registered output stage.
// The grant stays locked on one requester from its first non-last beat until its last beat transfers.
module rr_mux_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N-1:0]   req_last,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [IW-1:0]  out_idx,
    input  logic           out_ready,
    output logic           locked
);

    typedef enum logic {ST_OPEN, ST_LOCK} lock_state_t;

    lock_state_t   state_q, state_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [IW-1:0] out_idx_q, out_idx_d;

    logic [IW-1:0] sel;
    logic          cand_vld;
    logic          load_ok;
    logic          xfer;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Search starts just after the last completed burst, so that requester ends up lowest priority.
    always_comb begin
        sel      = '0;
        cand_vld = 1'b0;
        if (state_q == ST_LOCK) begin
            sel      = lock_idx_q;
            cand_vld = req_valid[lock_idx_q];
        end else begin
            for (int i = 1; i <= N; i++) begin
                if (!cand_vld && req_valid[wrap_add(ptr_q, i)]) begin
                    cand_vld = 1'b1;
                    sel      = wrap_add(ptr_q, i);
                end
            end
        end
    end

    assign load_ok = !out_valid_q || out_ready;
    assign xfer    = cand_vld && load_ok;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[sel] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        lock_idx_d  = lock_idx_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data[int'(sel)*W +: W];
            out_last_d  = req_last[sel];
            out_idx_d   = sel;
            if (req_last[sel]) begin
                state_d = ST_OPEN;
                ptr_d   = sel;
            end else begin
                state_d    = ST_LOCK;
                lock_idx_d = sel;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_OPEN;
            lock_idx_q  <= '0;
            ptr_q       <= IW'(N - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_idx_q  <= lock_idx_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign locked    = (state_q == ST_LOCK);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter with a behavioural arbitration model.
module tb_rr_mux_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [IW-1:0]  out_idx;
    logic           out_ready;
    logic           locked;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.N(N), .W(W), .IW(IW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_idx(out_idx), .out_ready(out_ready), .locked(locked)
    );

    typedef struct {
        int           idx;
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           m_ptr, m_lock_idx;
    bit           m_locked, m_out_valid;
    logic [N-1:0] acc;
    int           rem[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    // Expected req_ready from the spec rules: held requester when locked, otherwise the first valid after ptr.
    function automatic logic [N-1:0] predict();
        int sel;
        sel = -1;
        if (m_locked) begin
            if (req_valid[m_lock_idx]) sel = m_lock_idx;
        end else begin
            for (int off = 1; off <= N; off++) begin
                int k;
                k = (m_ptr + off) % N;
                if (sel < 0 && req_valid[k]) sel = k;
            end
        end
        if (sel >= 0 && (!m_out_valid || out_ready)) return onehot(sel);
        return '0;
    endfunction

    task automatic step(input logic [N-1:0] want, input bit use_want);
        logic [N-1:0] e;
        #1;
        e = predict();
        chk("req_ready", req_ready, e);
        chk("locked", locked, m_locked);
        chk("out_valid", out_valid, m_out_valid);
        if (use_want) chk("req_ready_directed", req_ready, want);
        @(posedge clk);
        #1;
        acc = e;
        if (e != '0) begin
            for (int k = 0; k < N; k++) begin
                if (e[k]) begin
                    exp_q.push_back('{idx: k, data: req_data[k*W +: W], last: req_last[k]});
                    m_out_valid = 1'b1;
                    if (req_last[k]) begin
                        m_locked = 1'b0;
                        m_ptr    = k;
                    end else begin
                        m_locked   = 1'b1;
                        m_lock_idx = k;
                    end
                end
            end
        end else if (out_ready) begin
            m_out_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ptr       = N - 1;
        m_lock_idx  = 0;
        m_locked    = 1'b0;
        m_out_valid = 1'b0;
        acc         = '0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: actual out_valid=1 idx=%0d required no beat", out_idx);
                end else begin
                    chk("out_idx", out_idx, exp_q[0].idx);
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_last", out_last, exp_q[0].last);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    logic [N-1:0] lk_valid[5] = '{4'b0111, 4'b0111, 4'b0111, 4'b0011, 4'b0010};
    logic [W-1:0] lk_data[3]  = '{8'h11, 8'h22, 8'h33};
    logic [N-1:0] lk_want[5]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0010};

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_locked", locked, 0);
        reset_n   = 1'b1;

        out_ready = 1'b1;
        repeat (5) step('0, 1'b1);

        req_valid = '1;
        req_last  = '1;
        for (int k = 0; k < N; k++) req_data[k*W +: W] = W'(8'hA0 + k);
        for (int i = 0; i < 6; i++) step(onehot(i % N), 1'b1);

        req_data[0*W +: W] = 8'h50;
        req_data[1*W +: W] = 8'h51;
        for (int i = 0; i < 5; i++) begin
            req_valid = lk_valid[i];
            if (i < 3) begin
                req_data[2*W +: W] = lk_data[i];
                req_last[2]        = (i == 2);
            end
            step(lk_want[i], 1'b1);
        end

        req_valid          = 4'b1000;
        req_data[3*W +: W] = 8'h77;
        req_last[3]        = 1'b1;
        step(4'b1000, 1'b1);
        req_data[3*W +: W] = 8'h78;
        out_ready          = 1'b0;
        repeat (4) step('0, 1'b1);
        out_ready = 1'b1;
        step(4'b1000, 1'b1);

        req_valid          = 4'b0001;
        req_data[0*W +: W] = 8'h99;
        req_last[0]        = 1'b0;
        step(4'b0001, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_locked", locked, 0);
        chk("async_rst_out_data", out_data, 0);
        model_reset();
        @(negedge clk);
        reset_n   = 1'b1;
        req_valid = '1;
        req_last  = '1;
        step(4'b0001, 1'b1);
        req_valid = '0;
        step('0, 1'b1);

        for (int k = 0; k < N; k++) rem[k] = 0;
        acc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (acc[k]) rem[k]--;
                if (!req_valid[k] || acc[k]) begin
                    if ($urandom % 100 < 55) begin
                        if (rem[k] == 0) rem[k] = 1 + int'($urandom % 4);
                        req_data[k*W +: W] = W'($urandom);
                        req_last[k]        = (rem[k] == 1);
                        req_valid[k]       = 1'b1;
                    end else begin
                        req_valid[k] = 1'b0;
                    end
                end
            end
            out_ready = ($urandom % 100) < 70;
            step('0, 1'b0);
        end

        req_valid = '0;
        out_ready = 1'b1;
        repeat (3) step('0, 1'b1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
